// File: rtl/mem_responder_if.sv
// Memory port bundle between the processor datapath (master) and the memory responder (slave).
interface mem_responder_if;
  logic        mem_req;
  logic        mem_write;
  logic [31:0] adr;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        mem_ready;
  logic        mem_err;

  modport master (
    output mem_req, mem_write, adr, write_data,
    input  read_data, mem_ready, mem_err
  );

  modport slave (
    input  mem_req, mem_write, adr, write_data,
    output read_data, mem_ready, mem_err
  );
endinterface

// File: rtl/mem_responder.sv
// Unified instruction/data word memory with a request/ready handshake and a fixed,
// parameterised number of wait states. Misaligned or out-of-range accesses return an
// error response instead of aliasing onto an in-range word.
module mem_responder #(
  parameter int unsigned AW      = 6,  // log2 of depth in 32-bit words
  parameter int unsigned LATENCY = 2   // edges from acceptance to response, 1..15
) (
  input logic           clk,
  input logic           reset,
  mem_responder_if.slave bus
);

  localparam int unsigned Depth     = 1 << AW;
  localparam logic [3:0]  CntLoad   = 4'(LATENCY - 1);
  localparam logic [31:0] ErrorWord = 32'hDEADBEEF;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e        state;
  logic [3:0]    cnt;
  logic          write_q;
  logic [31:0]   adr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          ready_q;
  logic          err_q;

  logic [31:0]   mem [Depth];

  logic [AW-1:0] index;
  logic          addr_err;
  logic          access;

  // Decode always works on the captured address, so late input changes cannot leak in.
  assign index    = adr_q[AW+1:2];
  assign addr_err = (adr_q[1:0] != 2'b00) || ((adr_q >> (AW + 2)) != 32'd0);
  assign access   = (state == StWait) && (cnt == 4'd0);

  assign bus.read_data = rdata_q;
  assign bus.mem_ready = ready_q;
  assign bus.mem_err   = err_q;

  // Handshake FSM: accept in IDLE/RESP, count wait states, then emit a one-cycle response.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= StIdle;
      cnt     <= 4'd0;
      write_q <= 1'b0;
      adr_q   <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      unique case (state)
        StIdle, StResp: begin
          if (bus.mem_req) begin
            write_q <= bus.mem_write;
            adr_q   <= bus.adr;
            wdata_q <= bus.write_data;
            cnt     <= CntLoad;
            state   <= StWait;
          end else begin
            state <= StIdle;
          end
        end
        StWait: begin
          // Requests arriving here are dropped; the requester must hold or re-issue.
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state   <= StResp;
            ready_q <= 1'b1;
            err_q   <= addr_err;
            if (addr_err) begin
              rdata_q <= ErrorWord;
            end else if (write_q) begin
              rdata_q <= wdata_q;
            end else begin
              rdata_q <= mem[index];
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  // Array commit on the WAIT->RESP edge; contents survive reset, and an aborted write never lands.
  always_ff @(posedge clk) begin
    if (!reset && access && write_q && !addr_err) begin
      mem[index] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: expected responses are queued at issue time and
// compared when each response strobe appears.
module tb_mem_responder;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_responder_if bus1 ();
  mem_responder_if bus2 ();
  mem_responder_if bus15 ();

  mem_responder #(.AW(6), .LATENCY(1)) dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus1.slave)
  );

  mem_responder #(.AW(6), .LATENCY(2)) dut2 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus2.slave)
  );

  mem_responder #(.AW(6), .LATENCY(15)) dut15 (
    .clk  (clk),
    .reset(reset),
    .bus  (bus15.slave)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        err;
  } resp_t;

  resp_t sb_q[$];
  int    n_checks = 0;
  int    n_pass   = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    ready_cnt2 = 0;
  int    last_ready_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus2.mem_ready === 1'b1) ready_cnt2 <= ready_cnt2 + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic req, input logic we, input logic [31:0] a,
                       input logic [31:0] wd);
    case (w)
      1: begin
        bus1.mem_req = req; bus1.mem_write = we; bus1.adr = a; bus1.write_data = wd;
      end
      15: begin
        bus15.mem_req = req; bus15.mem_write = we; bus15.adr = a; bus15.write_data = wd;
      end
      default: begin
        bus2.mem_req = req; bus2.mem_write = we; bus2.adr = a; bus2.write_data = wd;
      end
    endcase
  endtask

  function automatic logic rdy(input int w);
    case (w)
      1:       return bus1.mem_ready;
      15:      return bus15.mem_ready;
      default: return bus2.mem_ready;
    endcase
  endfunction

  function automatic resp_t resp(input int w);
    resp_t r;
    case (w)
      1:       begin r.data = bus1.read_data;  r.err = bus1.mem_err;  end
      15:      begin r.data = bus15.read_data; r.err = bus15.mem_err; end
      default: begin r.data = bus2.read_data;  r.err = bus2.mem_err;  end
    endcase
    return r;
  endfunction

  // Counts edges until the response strobe is seen; -1 if the budget runs out.
  task automatic wait_ready(input int w, output int edges);
    edges = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      edges++;
      if (rdy(w) === 1'b1) return;
    end
    edges = -1;
  endtask

  task automatic xact(input int w, input string tag, input logic we, input logic [31:0] a,
                      input logic [31:0] wd, input logic [31:0] exp_data, input logic exp_err,
                      input int exp_lat);
    resp_t e;
    resp_t got;
    int    edges;
    e.data = exp_data;
    e.err  = exp_err;
    sb_q.push_back(e);
    drive(w, 1'b1, we, a, wd);
    @(posedge clk);
    #1;
    // Scramble the bus after acceptance; the in-flight access must not notice.
    drive(w, 1'b0, 1'($urandom), $urandom(), $urandom());
    wait_ready(w, edges);
    check({tag, " latency"}, 32'(edges), 32'(exp_lat));
    e = sb_q.pop_front();
    if (edges >= 0) begin
      got = resp(w);
      check({tag, " data"}, got.data, e.data);
      check({tag, " err"}, {31'd0, got.err}, {31'd0, e.err});
    end
    last_ready_cyc = cyc;
  endtask

  initial begin
    int    prev;
    int    c0;
    int    edges;
    resp_t e;
    resp_t got;

    reset = 1'b1;
    drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(2, 1'b0, 1'b0, 32'd0, 32'd0);
    drive(15, 1'b0, 1'b0, 32'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset ready", {31'd0, bus2.mem_ready}, 32'd0);
    check("reset err", {31'd0, bus2.mem_err}, 32'd0);
    check("reset data", bus2.read_data, 32'd0);

    xact(2, "wr 0x10", 1'b1, 32'h10, 32'h12345678, 32'h12345678, 1'b0, 2);
    prev = last_ready_cyc;
    // Issued during the RESP cycle: back-to-back.
    xact(2, "rd 0x10 b2b", 1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0, 2);
    check("b2b gap", 32'(last_ready_cyc - prev), 32'd3);
    @(posedge clk);
    #1;
    check("ready one cycle", {31'd0, bus2.mem_ready}, 32'd0);

    xact(2, "wr misaligned", 1'b1, 32'h12, 32'hFFFFFFFF, 32'hDEADBEEF, 1'b1, 2);
    xact(2, "rd after misaligned", 1'b0, 32'h10, 32'h0, 32'h12345678, 1'b0, 2);

    xact(2, "wr word0", 1'b1, 32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 2);
    xact(2, "wr 0x100", 1'b1, 32'h100, 32'h0000005A, 32'hDEADBEEF, 1'b1, 2);
    xact(2, "rd 0x100", 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b1, 2);
    xact(2, "rd word0 no alias", 1'b0, 32'h0, 32'h0, 32'hA5A5A5A5, 1'b0, 2);
    xact(2, "wr top", 1'b1, 32'hFC, 32'hFCFCFCFC, 32'hFCFCFCFC, 1'b0, 2);
    xact(2, "rd top", 1'b0, 32'hFC, 32'h0, 32'hFCFCFCFC, 1'b0, 2);
    xact(2, "wr 0x04", 1'b1, 32'h04, 32'h44444444, 32'h44444444, 1'b0, 2);
    xact(2, "wr 0x20 zero", 1'b1, 32'h20, 32'h0, 32'h0, 1'b0, 2);

    // Write aborted by reset one edge after acceptance.
    drive(2, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    c0 = ready_cnt2;
    reset = 1'b1;
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("abort data cleared", bus2.read_data, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    check("abort no ready", 32'(ready_cnt2 - c0), 32'd0);
    xact(2, "rd 0x20 after abort", 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 2);

    // Request pulsed during WAIT must be dropped.
    e.data = 32'h12345678;
    e.err  = 1'b0;
    sb_q.push_back(e);
    drive(2, 1'b1, 1'b0, 32'h10, 32'h0);
    @(posedge clk);
    #1;
    c0 = ready_cnt2;
    drive(2, 1'b1, 1'b1, 32'h04, 32'h00000077);
    @(posedge clk);
    #1;
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    wait_ready(2, edges);
    check("pulse latency", 32'(edges), 32'd1);
    e = sb_q.pop_front();
    got = resp(2);
    check("pulse data", got.data, e.data);
    check("pulse err", {31'd0, got.err}, {31'd0, e.err});
    repeat (5) @(posedge clk);
    #1;
    check("pulse single ready", 32'(ready_cnt2 - c0), 32'd1);
    xact(2, "rd 0x04 after pulse", 1'b0, 32'h04, 32'h0, 32'h44444444, 1'b0, 2);

    xact(1, "lat1 wr", 1'b1, 32'h0, 32'h11110001, 32'h11110001, 1'b0, 1);
    xact(1, "lat1 rd", 1'b0, 32'h0, 32'h0, 32'h11110001, 1'b0, 1);
    xact(15, "lat15 wr", 1'b1, 32'h0, 32'h15150015, 32'h15150015, 1'b0, 15);
    xact(15, "lat15 rd", 1'b0, 32'h0, 32'h0, 32'h15150015, 1'b0, 15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
